// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : multi_cycle_ctrl
// Brief   : Moore control FSM sequencing fetch/decode/execute/memory/write-back
//           for the multi-cycle MIPS datapath, plus completion/illegal/retire.
// Revision: 1.0 - initial release
//==============================================================================
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemWr,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWr,
    output logic             RegDst,
    output logic [3:0]       state,
    output logic             inst_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_wr;
        logic       reg_dst;
        logic       inst_done;
    } ctrl_t;

    localparam logic [5:0]       c_op_rtype = 6'b000000;
    localparam logic [5:0]       c_op_lw    = 6'b100011;
    localparam logic [5:0]       c_op_sw    = 6'b101011;
    localparam logic [5:0]       c_op_beq   = 6'b000100;
    localparam logic [5:0]       c_op_j     = 6'b000010;
    localparam logic [5:0]       c_op_addi  = 6'b001000;
    localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_rd    = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_rd = 1'b1;
                c.iord   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
                c.inst_done  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_wr    = 1'b1;
                c.iord      = 1'b1;
                c.inst_done = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_wr    = 1'b1;
                c.reg_dst   = 1'b1;
                c.inst_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.inst_done     = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.inst_done = 1'b1;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_IWB: begin
                c.reg_wr    = 1'b1;
                c.inst_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_op_lw, c_op_sw: n = S_MEMADR;
                    c_op_rtype:       n = S_EXEC;
                    c_op_beq:         n = S_BRANCH;
                    c_op_j:           n = S_JUMP;
                    c_op_addi:        n = S_IEXEC;
                    default:          n = S_FETCH;
                endcase
            end
            S_MEMADR: n = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  n = S_MEMWB;
            S_EXEC:   n = S_RWB;
            S_IEXEC:  n = S_IWB;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_retired;

    state_t w_next_state;
    logic   w_state_valid;
    logic   w_op_supported;
    ctrl_t  w_ctrl;

    assign w_next_state  = next_state(r_state, opcode);
    assign w_state_valid = (r_state <= S_IWB);

    always_comb begin
        w_op_supported = 1'b0;
        case (opcode)
            c_op_rtype, c_op_lw, c_op_sw,
            c_op_beq, c_op_j, c_op_addi: w_op_supported = 1'b1;
            default:                     w_op_supported = 1'b0;
        endcase
    end

    // Control vector is pre-decoded from the next state so outputs come
    // straight from flops; a corrupted state code masks everything to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ctrl    <= decode_ctrl(S_FETCH);
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= decode_ctrl(w_next_state);
            if (w_state_valid && r_ctrl.inst_done) begin
                r_retired <= r_retired + c_one;
            end
        end
    end

    assign w_ctrl = w_state_valid ? r_ctrl : '0;

    // Enables are gated by rst directly so an asynchronous reset kills any
    // in-flight write immediately rather than at the next edge.
    assign PCWrite     = w_ctrl.pc_write      & ~rst;
    assign PCWriteCond = w_ctrl.pc_write_cond & ~rst;
    assign MemRd       = w_ctrl.mem_rd        & ~rst;
    assign MemWr       = w_ctrl.mem_wr        & ~rst;
    assign IRWrite     = w_ctrl.ir_write      & ~rst;
    assign RegWr       = w_ctrl.reg_wr        & ~rst;
    assign inst_done   = w_ctrl.inst_done     & ~rst;
    assign IorD        = w_ctrl.iord;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUOp       = w_ctrl.alu_op;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign RegDst      = w_ctrl.reg_dst;

    assign illegal = ~rst & (r_state == S_DECODE) & ~w_op_supported;
    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : tb_multi_cycle_ctrl
// Brief   : Randomized self-checking bench for multi_cycle_ctrl against a
//           per-instruction state-sequence model.
// Revision: 1.0 - initial release
//==============================================================================
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 4;
    localparam logic [5:0] c_op_rt   = 6'b000000;
    localparam logic [5:0] c_op_lw   = 6'b100011;
    localparam logic [5:0] c_op_sw   = 6'b101011;
    localparam logic [5:0] c_op_beq  = 6'b000100;
    localparam logic [5:0] c_op_j    = 6'b000010;
    localparam logic [5:0] c_op_addi = 6'b001000;
    localparam logic [16:0] c_reset_ctrl = 17'b0000000_00_00_0_01_0_0_0;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg;
    logic [1:0]       PCSource, ALUOp, ALUSrcB;
    logic             ALUSrcA, RegWr, RegDst, inst_done, illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic [16:0]      obs_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] m_retired;

    logic [3:0]       e_st[8], o_st[8];
    logic [16:0]      o_ctrl[8];
    logic             e_ill[8], o_ill[8];
    logic [CNT_W-1:0] e_ret[8], o_ret[8];
    int               e_n, o_n;

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRd(MemRd), .MemWr(MemWr), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWr(RegWr), .RegDst(RegDst), .state(state), .inst_done(inst_done),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite, MemtoReg,
                       PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWr, RegDst, inst_done};

    function automatic logic [16:0] exp_ctrl(input logic [3:0] s);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst, done;
        logic [1:0] pcs, aop, srcb;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst, done} = 11'b0;
        pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; done = 1; end
            4'd5:  begin mwr = 1; iord = 1; done = 1; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rdst = 1; done = 1; end
            4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, srca, srcb, rw, rdst, done};
    endfunction

    // Model: expected state walk per opcode; drive: feed opcode as IR would.
    task automatic run_and_model(input logic [5:0] op);
        logic [3:0] seq[$];
        bit legal;
        legal = 1'b1;
        case (op)
            c_op_lw:   seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            c_op_sw:   seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            c_op_rt:   seq = '{4'd0, 4'd1, 4'd6, 4'd7};
            c_op_addi: seq = '{4'd0, 4'd1, 4'd10, 4'd11};
            c_op_beq:  seq = '{4'd0, 4'd1, 4'd8};
            c_op_j:    seq = '{4'd0, 4'd1, 4'd9};
            default: begin seq = '{4'd0, 4'd1}; legal = 1'b0; end
        endcase
        e_n = seq.size();
        for (int i = 0; i < e_n; i++) begin
            e_st[i]  = seq[i];
            e_ill[i] = (i == 1) && !legal;
            e_ret[i] = m_retired;
        end
        if (legal) m_retired = m_retired + 1'b1;
        o_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            o_st[c] = state; o_ctrl[c] = obs_ctrl; o_ill[c] = illegal; o_ret[c] = retired;
            @(posedge clk);
            #1;
            if (c == 0) opcode = op;
            o_n = c + 1;
            if (state == 4'd0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'd0; m_retired = '0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d expected 0", state); end
        n_tests++; if (obs_ctrl !== c_reset_ctrl) begin n_fail++; $display("FAIL reset_ctrl got %b expected %b", obs_ctrl, c_reset_ctrl); end
        n_tests++; if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got %0d expected 0", retired); end
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b expected 0", illegal); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++; if (obs_ctrl !== exp_ctrl(4'd0) || state !== 4'd0) begin
            n_fail++; $display("FAIL release_fetch got state %0d ctrl %b expected 0 %b", state, obs_ctrl, exp_ctrl(4'd0));
        end
    endtask

    task automatic test_sequences();
        logic [5:0] ops[7];
        ops = '{c_op_lw, c_op_sw, c_op_rt, c_op_addi, c_op_beq, c_op_j, 6'b111111};
        for (int k = 0; k < 7; k++) begin
            run_and_model(ops[k]);
            n_tests++; if (o_n !== e_n) begin n_fail++; $display("FAIL seq_len op=%b got %0d expected %0d", ops[k], o_n, e_n); end
            for (int i = 0; i < e_n; i++) begin
                n_tests++; if (o_st[i] !== e_st[i]) begin n_fail++; $display("FAIL seq_state op=%b cyc %0d got %0d expected %0d", ops[k], i, o_st[i], e_st[i]); end
                n_tests++; if (o_ctrl[i] !== exp_ctrl(e_st[i])) begin n_fail++; $display("FAIL seq_ctrl op=%b cyc %0d got %b expected %b", ops[k], i, o_ctrl[i], exp_ctrl(e_st[i])); end
                n_tests++; if (o_ill[i] !== e_ill[i]) begin n_fail++; $display("FAIL seq_illegal op=%b cyc %0d got %b expected %b", ops[k], i, o_ill[i], e_ill[i]); end
                n_tests++; if (o_ret[i] !== e_ret[i]) begin n_fail++; $display("FAIL seq_retired op=%b cyc %0d got %0d expected %0d", ops[k], i, o_ret[i], e_ret[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] table_ops[8];
        logic [5:0] op;
        table_ops = '{c_op_lw, c_op_sw, c_op_rt, c_op_addi, c_op_beq, c_op_j, 6'd0, 6'd0};
        for (int k = 0; k < 40; k++) begin
            op = table_ops[$urandom_range(0, 7)];
            if (op == 6'd0 && $urandom_range(0, 1) == 1) op = 6'($urandom_range(0, 63));
            run_and_model(op);
            n_tests++; if (o_n !== e_n) begin n_fail++; $display("FAIL rnd_len op=%b got %0d expected %0d", op, o_n, e_n); end
            for (int i = 0; i < e_n; i++) begin
                n_tests++; if (o_st[i] !== e_st[i]) begin n_fail++; $display("FAIL rnd_state op=%b cyc %0d got %0d expected %0d", op, i, o_st[i], e_st[i]); end
                n_tests++; if (o_ctrl[i] !== exp_ctrl(e_st[i])) begin n_fail++; $display("FAIL rnd_ctrl op=%b cyc %0d got %b expected %b", op, i, o_ctrl[i], exp_ctrl(e_st[i])); end
                n_tests++; if (o_ill[i] !== e_ill[i]) begin n_fail++; $display("FAIL rnd_illegal op=%b cyc %0d got %b expected %b", op, i, o_ill[i], e_ill[i]); end
                n_tests++; if (o_ret[i] !== e_ret[i]) begin n_fail++; $display("FAIL rnd_retired op=%b cyc %0d got %0d expected %0d", op, i, o_ret[i], e_ret[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        @(posedge clk);
        #1 opcode = c_op_rt;
        @(posedge clk);
        #1;
        n_tests++; if (state !== 4'd6) begin n_fail++; $display("FAIL mid_exec_reach got %0d expected 6", state); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (state !== 4'd0) begin n_fail++; $display("FAIL mid_rst_state got %0d expected 0", state); end
        n_tests++; if (obs_ctrl !== c_reset_ctrl) begin n_fail++; $display("FAIL mid_rst_ctrl got %b expected %b", obs_ctrl, c_reset_ctrl); end
        n_tests++; if (retired !== '0) begin n_fail++; $display("FAIL mid_rst_retired got %0d expected 0", retired); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++; if (RegWr !== 1'b0 || state !== 4'd0) begin
                n_fail++; $display("FAIL mid_rst_hold cyc %0d got RegWr %b state %0d expected 0 0", c, RegWr, state);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        m_retired = '0;
        #1;
        n_tests++; if (state !== 4'd0 || obs_ctrl !== exp_ctrl(4'd0)) begin
            n_fail++; $display("FAIL mid_release got state %0d ctrl %b expected 0 %b", state, obs_ctrl, exp_ctrl(4'd0));
        end
        run_and_model(c_op_rt);
        n_tests++; if (o_n !== 4 || o_st[2] !== 4'd6 || o_st[3] !== 4'd7) begin
            n_fail++; $display("FAIL mid_resume got len %0d st2 %0d st3 %0d expected 4 6 7", o_n, o_st[2], o_st[3]);
        end
        #1;
        n_tests++; if (retired !== m_retired) begin n_fail++; $display("FAIL mid_resume_retired got %0d expected %0d", retired, m_retired); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 20 && m_retired != 4'hF; k++) run_and_model(c_op_rt);
        #1;
        n_tests++; if (retired !== 4'hF) begin n_fail++; $display("FAIL wrap_pre got %0d expected 15", retired); end
        run_and_model(c_op_rt);
        #1;
        n_tests++; if (retired !== 4'h0) begin n_fail++; $display("FAIL wrap_post got %0d expected 0", retired); end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_random();
        test_reset_mid_exec();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
